// File: rtl/decision_thr_pkg.sv
// Shared constants for the adaptive decision-threshold (R) update datapath.
package decision_thr_pkg;

  // Default operand geometry: unsigned fixed point with FRAC fraction bits.
  localparam int DW_DEF   = 16;
  localparam int CW_DEF   = 16;
  localparam int FRAC_DEF = 8;
  localparam int NCH_DEF  = 3;

  // Default adaptation coefficients (8 fraction bits).
  localparam logic [15:0] RSCALE_DEF         = 16'h0500;
  localparam logic [15:0] RLOW_DEF           = 16'h1200;
  localparam logic [15:0] RHIGH_DEF          = 16'hFFFF;
  localparam logic [15:0] ONE_MINUS_RINC_DEF = 16'h00f3;
  localparam logic [15:0] ONE_PLUS_RINC_DEF  = 16'h010d;

endpackage

// File: rtl/decision_thr_lane.sv
// One channel of the R update: compare, scale, saturate, clamp.
// Stage A registers dmin*rscale, B registers rx*multiplier, C saturates,
// D clamps into the output register. Coefficients arrive already aligned
// to the stage that consumes them.
module decision_thr_lane
  import decision_thr_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] rx_i,
  input  logic [DW-1:0] dmin_i,
  input  logic [CW-1:0] rscale_i,
  input  logic [CW-1:0] mul_dec_i,
  input  logic [CW-1:0] mul_inc_i,
  input  logic          freeze_i,
  input  logic [DW-1:0] rlow_i,
  input  logic [DW-1:0] rhigh_i,
  input  logic          out_en_i,
  output logic [DW-1:0] rnx_o,
  output logic          sat_o
);

  localparam int PW = DW + CW;
  localparam int SW = PW - FRAC;

  logic [PW-1:0] p_q;
  logic [DW-1:0] rx_a_q;
  logic [PW-1:0] prod_q;
  logic [DW-1:0] rx_b_q;
  logic [DW-1:0] m_q;
  logic          sat2_q;
  logic [DW-1:0] rnx_q;
  logic          sat_q;

  logic          dec;
  logic [CW-1:0] mul_sel;
  logic [SW-1:0] shifted;
  logic          over;
  logic [DW-1:0] m_d;
  logic          sat2_d;
  logic [DW-1:0] rnx_d;
  logic          sat_d;

  // Stage A: scaled distance product, R travels alongside.
  always_ff @(posedge clk) begin
    p_q    <= {{CW{1'b0}}, dmin_i} * {{DW{1'b0}}, rscale_i};
    rx_a_q <= rx_i;
  end

  // Decrease only when R (aligned to the product scale) strictly exceeds dmin*rscale.
  always_comb begin
    dec     = ({{(CW - FRAC){1'b0}}, rx_a_q, {FRAC{1'b0}}} > p_q);
    mul_sel = dec ? mul_dec_i : mul_inc_i;
  end

  // Stage B: apply the chosen multiplier.
  always_ff @(posedge clk) begin
    prod_q <= {{CW{1'b0}}, rx_a_q} * {{DW{1'b0}}, mul_sel};
    rx_b_q <= rx_a_q;
  end

  // Truncate the fraction and saturate to DW bits; freeze bypasses adaptation.
  always_comb begin
    shifted = prod_q[PW-1:FRAC];
    over    = |shifted[SW-1:DW];
    m_d     = shifted[DW-1:0];
    sat2_d  = 1'b0;
    if (freeze_i) begin
      m_d = rx_b_q;
    end else if (over) begin
      m_d    = {DW{1'b1}};
      sat2_d = 1'b1;
    end
  end

  // Stage C: saturated result.
  always_ff @(posedge clk) begin
    m_q    <= m_d;
    sat2_q <= sat2_d;
  end

  // Clamp to [rlow, rhigh]; the lower bound wins when the window is inverted.
  always_comb begin
    rnx_d = m_q;
    sat_d = sat2_q;
    if (m_q < rlow_i) begin
      rnx_d = rlow_i;
      sat_d = 1'b1;
    end else if (m_q > rhigh_i) begin
      rnx_d = rhigh_i;
      sat_d = 1'b1;
    end
  end

  // Stage D: output register, updated only for valid pixels so gaps hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnx_q <= '0;
      sat_q <= 1'b0;
    end else if (out_en_i) begin
      rnx_q <= rnx_d;
      sat_q <= sat_d;
    end
  end

  assign rnx_o = rnx_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/decision_thr_mc.sv
// Multi-channel R update: NCH lock-step lanes, shared valid and coefficient pipeline.
module decision_thr_mc
  import decision_thr_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int NCH  = NCH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rv,
  input  logic [NCH*DW-1:0] rx,
  input  logic [NCH*DW-1:0] dmin,
  input  logic [CW-1:0]     rscale,
  input  logic [DW-1:0]     rlow,
  input  logic [DW-1:0]     rhigh,
  input  logic [CW-1:0]     one_minus_rinc,
  input  logic [CW-1:0]     one_plus_rinc,
  input  logic              freeze,
  output logic              rnv,
  output logic [NCH*DW-1:0] rnx,
  output logic [NCH-1:0]    sat
);

  logic [3:0]    v_q;
  logic [CW-1:0] mul_dec_a_q, mul_inc_a_q;
  logic          freeze_a_q, freeze_b_q;
  logic [DW-1:0] rlow_a_q, rlow_b_q, rlow_c_q;
  logic [DW-1:0] rhigh_a_q, rhigh_b_q, rhigh_c_q;

  // Valid shift register; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= {v_q[2:0], rv};
    end
  end

  // Per-pixel controls ride along with the data to the stage that uses them.
  always_ff @(posedge clk) begin
    mul_dec_a_q <= one_minus_rinc;
    mul_inc_a_q <= one_plus_rinc;
    freeze_a_q  <= freeze;
    freeze_b_q  <= freeze_a_q;
    rlow_a_q    <= rlow;
    rlow_b_q    <= rlow_a_q;
    rlow_c_q    <= rlow_b_q;
    rhigh_a_q   <= rhigh;
    rhigh_b_q   <= rhigh_a_q;
    rhigh_c_q   <= rhigh_b_q;
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
      decision_thr_lane #(
        .DW   (DW),
        .CW   (CW),
        .FRAC (FRAC)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx[gi*DW +: DW]),
        .dmin_i    (dmin[gi*DW +: DW]),
        .rscale_i  (rscale),
        .mul_dec_i (mul_dec_a_q),
        .mul_inc_i (mul_inc_a_q),
        .freeze_i  (freeze_b_q),
        .rlow_i    (rlow_c_q),
        .rhigh_i   (rhigh_c_q),
        .out_en_i  (v_q[2]),
        .rnx_o     (rnx[gi*DW +: DW]),
        .sat_o     (sat[gi])
      );
    end
  endgenerate

  assign rnv = v_q[3];

endmodule

// File: doc/decision_thr_mc.md
Name: decision_thr_mc

Overview:
- Parametrised, multi-channel successor of the single-channel decision_thr unit for the PBAS-style adaptive background model.
- Per channel, updates the per-pixel decision threshold R from the minimum sample distance dmin. R decreases when R > dmin·Rscale and increases otherwise. The result is then clamped to a programmable [rlow, rhigh] window.
- Sits between the distance/min-search stage and the R-memory write-back. NCH channels (e.g. colour planes) are processed in lock-step, one pixel per clock, fully pipelined.

Parameters:
- DW, 16, width of R and dmin (unsigned fixed point, FRAC fraction bits).
- CW, 16, width of rscale / one_minus_rinc / one_plus_rinc (unsigned, FRAC fraction bits).
- FRAC, 8, fraction bits shared by all operands.
- NCH, 3, number of channels processed in parallel.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rv  in  1  input valid; one pixel (all channels) per cycle when high.
- rx  in  NCH*DW  current R per channel, channel 0 in LSBs.
- dmin  in  NCH*DW  minimum distance per channel.
- rscale  in  CW  distance scale factor.
- rlow  in  DW  lower R bound.
- rhigh  in  DW  upper R bound.
- one_minus_rinc  in  CW  decrease multiplier (1−Rinc).
- one_plus_rinc  in  CW  increase multiplier (1+Rinc).
- freeze  in  1  per-pixel: skip adaptation, pass rx through the clamp only.
- rnv  out  1  output valid.
- rnx  out  NCH*DW  updated R per channel.
- sat  out  NCH  per-channel flag: the result was clamped or saturated.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All valid pipeline bits are cleared.
  - rnv=0, rnx=0, sat=0.
  - In-flight samples are discarded and never emerge. The first valid output after reset comes 3 cycles after the first rv sampled with rst=0.
- Throughput and latency:
  - One pixel per cycle, no stall, no backpressure.
  - Fixed latency of 3 cycles: rv sampled at edge N gives rnv=1 after edge N+3.
- Sampling: rscale, rlow, rhigh, both multipliers and freeze are sampled together with rx/dmin on the rv cycle and travel with the data. Changing them between pixels affects only subsequent pixels.
- Stage 1:
  - p = dmin·rscale, a DW+CW-bit product.
  - dec = ({rx, FRAC'b0} > p), strictly greater. Equality gives dec=0 (increase).
- Stage 2:
  - m = rx·(dec ? one_minus_rinc : one_plus_rinc), then shifted right by FRAC (truncate, no rounding).
  - If m exceeds 2^DW−1, it becomes 2^DW−1 and sat_s2=1.
  - freeze=1: m = rx, dec ignored.
- Stage 3:
  - r = m; if m < rlow then r = rlow; else if m > rhigh then r = rhigh.
  - If rhigh < rlow, the rlow comparison has priority: any m < rlow gives rlow, any other m gives rhigh.
  - sat = sat_s2 OR either clamp taken.
- When rnv=0, rnx and sat hold their previous values.
- Channels are fully independent. NCH=1 must reproduce the behaviour of the single-channel decision_thr with rhigh=all-ones and freeze=0.

Decomposition:
- Package decision_thr_pkg:
  - Default DW/CW/FRAC constants.
  - Default coefficients: RSCALE_DEF=16'h0500, RLOW_DEF=16'h1200, ONE_MINUS_RINC_DEF=16'h00f3, ONE_PLUS_RINC_DEF=16'h010d, RHIGH_DEF=all-ones.
- Sub-module decision_thr_lane: the 3-stage datapath for one channel, with no valid logic. It is instantiated NCH times via generate.
- Top level owns the valid pipeline, the coefficient/freeze pipeline registers shared by all lanes, and reset.

Test Plan:
All cases use NCH=3 and coefficients 0x0500 / 0x1200 / rhigh=0xFFFF / 0x00f3 / 0x010d unless stated.
- Decrease: rx=0x2000, dmin=0x0400 (20<32) → rnx=0x1E60, sat=0, rnv exactly 3 cycles after rv.
- Increase and tie: rx=0x2000, dmin=0x0800 → 0x21A0. rx=0x1400, dmin=0x0400 (equal) → 0x1504 (increase).
- Clamps:
  - rx=0x1200, dmin=0 → 0x1116 raw → rnx=0x1200, sat=1.
  - rx=0xFFFF, dmin=0xFFFF → rnx=0xFFFF, sat=1.
  - Same stimulus with rhigh=0x8000 → rnx=0x8000, sat=1.
  - rlow=0x3000, rhigh=0x2000, rx=0x2000, dmin=0x0400 → rnx=0x3000.
- Freeze: freeze=1, rx=0x1000 → rnx=0x1200, sat=1. freeze=1, rx=0x2000 → rnx=0x2000, sat=0.
- Streaming and multi-channel:
  - 1000 back-to-back pixels with distinct per-channel random rx/dmin and a coefficient change mid-stream; compare against a reference model per channel.
  - rv gaps hold rnx.
- Reset mid-stream: assert rst for 1 cycle while 3 pixels are in flight → no rnv for those pixels. rnx=0 and sat=0 after reset. The next pixel emerges with latency 3.
